// File: rtl/pe_frame_loader.sv
// Bitstream frame loader: parses a sync header, then strobes N frame words into PE config memory.
// Optional trailer checksum compare when PE_FRAME_LOADER_CHECKSUM_EN is defined.
module pe_frame_loader #(
  parameter int MaxFramesPerCol = 32,
  parameter int FrameBitsPerRow = 32
) (
  input  logic                       UserCLK,
  input  logic                       rst,
  input  logic [31:0]                in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int IdxW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd5;
`ifdef PE_FRAME_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_LAST   = S_CHECK;
`else
  localparam logic [2:0] S_LAST   = S_DONE;
`endif

  logic [2:0]      state, nxt;
  logic [IdxW-1:0] idx, last;
  logic            rdy_q;
  logic            take;
  logic            sync, hdr_zero, hdr_big, hdr_ok;
  logic [31:0]     cnt;
  logic            unused_bits;
`ifdef PE_FRAME_LOADER_CHECKSUM_EN
  logic [31:0]     acc;
`endif

  // ready is low for as long as reset is held, high again straight after release
  assign in_ready = rdy_q & ~rst;
  assign take     = in_valid & in_ready;

  assign sync     = (in_data[31:16] == 16'hFAB0);
  assign cnt      = {24'h0, in_data[7:0]};
  assign hdr_zero = sync & (cnt == 32'd0);
  assign hdr_big  = sync & (cnt > 32'(MaxFramesPerCol));
  assign hdr_ok   = sync & ~hdr_zero & ~hdr_big;

  assign unused_bits = ^in_data[15:8];

  // next-state decode
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (take && hdr_ok)
          nxt = S_WAIT;
        else if (take && hdr_zero)
          nxt = S_DONE;
      end
      S_WAIT:   if (take) nxt = S_STROBE;
      S_STROBE: nxt = S_HOLD;
      S_HOLD:   nxt = (idx == last) ? S_LAST : S_WAIT;
`ifdef PE_FRAME_LOADER_CHECKSUM_EN
      S_CHECK:  if (take) nxt = S_DONE;
`endif
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // state and registered status outputs; strobe/done trail their state by one cycle
  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rdy_q       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      FrameStrobe <= '0;
    end else begin
      state <= nxt;
      busy  <= (nxt != S_IDLE);
      done  <= (state == S_DONE);
`ifdef PE_FRAME_LOADER_CHECKSUM_EN
      rdy_q <= (nxt == S_IDLE) | (nxt == S_WAIT) | (nxt == S_CHECK);
`else
      rdy_q <= (nxt == S_IDLE) | (nxt == S_WAIT);
`endif
      if (state == S_STROBE)
        FrameStrobe <= MaxFramesPerCol'(1) << idx;
      else
        FrameStrobe <= '0;
    end
  end

  // frame index, frame data and sticky error
  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      last      <= '0;
      FrameData <= '0;
      err       <= 1'b0;
    end else begin
      if (state == S_IDLE && take) begin
        err <= ~(hdr_ok | hdr_zero);
        if (hdr_ok) begin
          idx  <= '0;
          last <= IdxW'(cnt - 32'd1);
        end
      end
      if (state == S_WAIT && take)
        FrameData <= FrameBitsPerRow'(in_data);
      if (state == S_HOLD && idx != last)
        idx <= idx + 1'b1;
`ifdef PE_FRAME_LOADER_CHECKSUM_EN
      if (state == S_CHECK && take && in_data != acc)
        err <= 1'b1;
`endif
    end
  end

`ifdef PE_FRAME_LOADER_CHECKSUM_EN
  // running XOR of accepted frame words, restarted by each valid header
  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (state == S_IDLE && take && (hdr_ok | hdr_zero))
      acc <= '0;
    else if (state == S_WAIT && take)
      acc <= acc ^ in_data;
  end
`endif

endmodule

// File: doc/pe_frame_loader.md
PE_FRAME_LOADER -- requirements
Module: pe_frame_loader

Interface
REQ-001 The block SHALL have parameter MaxFramesPerCol, default 32, meaning FrameStrobe width and maximum frames per load.
REQ-002 The block SHALL have parameter FrameBitsPerRow, default 32, meaning FrameData width; only the value 32 is supported.
REQ-003 The block SHALL have port UserCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_data, input, 32 bits: bitstream word.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the loader accepts a word when in_valid and in_ready are both high at a rising edge.
REQ-008 The block SHALL have port FrameData, output, FrameBitsPerRow bits: frame word to the PE config memory.
REQ-009 The block SHALL have port FrameStrobe, output, MaxFramesPerCol bits: one-hot frame write strobe.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a load completes.
REQ-012 The block SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-013 States SHALL be IDLE, WAIT_DATA, STROBE, HOLD, CHECK (present only with the macro) and DONE; all outputs SHALL be registered.
REQ-014 Header format SHALL be: in_data[31:16] = 16'hFAB0 (sync), in_data[7:0] = frame count N.
REQ-015 In IDLE, in_ready SHALL be 1, and accepted words SHALL be handled as follows:
- valid sync with 1 <= N <= MaxFramesPerCol: clear err, idx = 0, go to WAIT_DATA.
- valid sync with N = 0: clear err, go to DONE.
- valid sync with N > MaxFramesPerCol: set err, stay in IDLE.
- sync mismatch: discard the word, set err, stay in IDLE.
REQ-016 In WAIT_DATA, in_ready SHALL be 1; an accepted word SHALL be registered onto FrameData, and the state SHALL go to STROBE.
REQ-017 In STROBE, FrameStrobe SHALL equal (1 << idx) for exactly one cycle, with FrameData stable, in_ready = 0, then go to HOLD.
REQ-018 In HOLD, FrameStrobe SHALL be 0, FrameData SHALL be held and in_ready SHALL be 0.
- If idx == N-1: go to CHECK (macro defined) or DONE (macro undefined).
- Otherwise: idx += 1, go to WAIT_DATA.
REQ-019 The per-frame cost SHALL be 3 cycles minimum (accept, STROBE, HOLD); FrameData SHALL be set up one cycle before the strobe and held one cycle after it.
REQ-020 In DONE, done SHALL be 1 for one cycle, in_ready SHALL be 0, then the state SHALL go to IDLE.
REQ-021 FrameData SHALL retain the last frame word until the next accepted data word.
REQ-022 in_valid low in WAIT_DATA SHALL stall indefinitely with no strobe and no timeout.
REQ-023 At most one FrameStrobe bit SHALL ever be high, and never outside STROBE.
REQ-024 idx SHALL be ceil(log2(MaxFramesPerCol)) bits wide and SHALL never wrap, because N is bounded per REQ-015.

Reset
REQ-025 When rst is asserted, the block SHALL immediately (asynchronously) apply:
- state = IDLE, idx = 0
- FrameData = 0, FrameStrobe = 0
- busy = 0, done = 0, err = 0
- in_ready = 0 while rst is high, 1 in the first cycle after release.
REQ-026 Reset during STROBE SHALL drop the strobe asynchronously; a partial load SHALL be abandoned with no done pulse.

Configuration
REQ-027 Macro PE_FRAME_LOADER_CHECKSUM_EN SHALL control the checksum feature.
- Defined: a 32-bit XOR accumulator of all accepted data words is kept and cleared on a valid header. After the last HOLD, CHECK accepts one trailer word (in_ready = 1). Trailer equal to the accumulator: go to DONE. Mismatch: set err and go to DONE; done still pulses.
- Undefined: no accumulator, no CHECK state, and HOLD of the last frame goes directly to DONE.

Verification
REQ-028 The bench SHALL cover a basic load: header 32'hFAB0_0002, data 32'hDEAD_BEEF, 32'h1234_5678 -> FrameStrobe 32'h1 with FrameData DEADBEEF, then 32'h2 with FrameData 12345678, each strobe one cycle; done pulses once; err = 0.
REQ-029 The bench SHALL cover bad headers: header 32'hFAB1_0001 -> err = 1, no strobe, busy = 0; then header 32'hFAB0_0021 with Max = 32 -> err = 1, no strobe.
REQ-030 The bench SHALL cover a zero count: header 32'hFAB0_0000 -> done pulses 2 cycles after acceptance, no strobe.
REQ-031 The bench SHALL cover a stall: header N = 1, in_valid low 10 cycles in WAIT_DATA -> FrameStrobe stays 0; word 32'hA5A5_A5A5 -> strobe 32'h1.
REQ-032 The bench SHALL cover reset mid-load: rst asserted while FrameStrobe = 32'h4 -> FrameStrobe = 0 and FrameData = 0 immediately; no done pulse.
REQ-033 The bench SHALL cover the checksum (macro defined): header N = 2, data 32'h0000_00FF, 32'h0000_0F00, trailer 32'h0000_0FFF -> done, err = 0; the same load with trailer 32'h0 -> done, err = 1.
